// File: rtl/sb_pkg.sv
// sb_pkg: types and constants shared by the scoreboard controller, its
// round-robin arbiter and the scoreboard itself.
//   entry_t  : {cmd_id, proc_id} hashmap entry
//   op_t     : scoreboard operation (write = insert, read = lookup, flush = remove)
//   state_t  : controller FSM states
// PROC_COUNT follows the `PROC_COUNT macro when the build provides one.
`ifndef PROC_COUNT
`define PROC_COUNT 8
`endif

package sb_pkg;
    localparam int PROC_COUNT = `PROC_COUNT;
    localparam int PROC_ID_W  = $clog2(PROC_COUNT);
    localparam int CMD_ID_W   = 8;

    typedef struct packed {
        logic [CMD_ID_W-1:0]  cmd_id;
        logic [PROC_ID_W-1:0] proc_id;
    } entry_t;

    typedef enum logic [1:0] {
        OP_WRITE,
        OP_READ,
        OP_FLUSH
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Requester positions in the arbiter vectors.
    localparam int PORT_RET = 0;
    localparam int PORT_ISS = 1;
    localparam int PORT_QRY = 2;
endpackage

// File: rtl/rr_arb3.sv
// rr_arb3: 3-input round-robin arbiter with a request mask.
//   i_clk, i_rstn : clock, async active-low reset
//   i_req         : raw requests
//   i_mask        : 1 removes the matching request from arbitration
//   i_accept      : a granted request was taken; pointer moves past the winner
//   o_grant       : one-hot grant (zero when nothing eligible)
// The pointer names the highest-priority input and resets to input 0.
module rr_arb3 (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [2:0] i_req,
    input  logic [2:0] i_mask,
    input  logic       i_accept,
    output logic [2:0] o_grant
);
    logic [1:0] r_ptr;
    logic [2:0] w_req;
    logic [2:0] w_rot;
    logic [2:0] w_grot;

    assign w_req = i_req & ~i_mask;

    // Rotate so bit 0 is the pointer position, pick the first, rotate back.
    always_comb begin
        w_rot   = w_req;
        o_grant = '0;
        case (r_ptr)
            2'd1:    w_rot = {w_req[0], w_req[2], w_req[1]};
            2'd2:    w_rot = {w_req[1], w_req[0], w_req[2]};
            default: w_rot = w_req;
        endcase
        w_grot = w_rot[0] ? 3'b001 : (w_rot[1] ? 3'b010 : (w_rot[2] ? 3'b100 : 3'b000));
        case (r_ptr)
            2'd1:    o_grant = {w_grot[1], w_grot[0], w_grot[2]};
            2'd2:    o_grant = {w_grot[0], w_grot[2], w_grot[1]};
            default: o_grant = w_grot;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_ptr <= 2'd0;
        end else if (i_accept) begin
            if (o_grant[0])      r_ptr <= 2'd1;
            else if (o_grant[1]) r_ptr <= 2'd2;
            else if (o_grant[2]) r_ptr <= 2'd0;
        end
    end
endmodule

// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: sequencing front-end for the cmd_id->proc_id scoreboard.
// Arbitrates issue/retire/query requesters round-robin, runs one scoreboard
// operation at a time over the strobe/ack interface, tracks occupancy and
// returns per-port response pulses.
//   i_clk, i_rstn              : clock, async active-low reset (shared with scoreboard)
//   i_iss_* / o_iss_ready      : insert requests (entry_t)
//   i_ret_* / o_ret_ready      : remove requests; o_ret_done/o_ret_hit response
//   i_qry_* / o_qry_ready      : lookup requests; o_qry_rsp_valid/exists/proc_id response
//   o_sb_entry, o_sb_write/read/flush, i_sb_ack/exists/id : scoreboard side
//   o_count, o_full            : live entry count, count == PROC_COUNT-1
//   o_timeout                  : sticky ack watchdog flag
// Build option: SB_CTRL_TIMEOUT_EN enables the WAIT watchdog (TIMEOUT cycles).
//
// state    | meaning
// ST_IDLE  | readies follow the grant; a handshake latches op and entry
// ST_ISSUE | single-cycle scoreboard strobe
// ST_WAIT  | strobes low, entry held, waiting for i_sb_ack
// ST_RESP  | one-cycle response pulse and count update
module scoreboard_ctrl import sb_pkg::*; #(
    parameter int PROC_COUNT = sb_pkg::PROC_COUNT,
    parameter int TIMEOUT    = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_iss_valid,
    output logic                          o_iss_ready,
    input  entry_t                        i_iss_entry,
    input  logic                          i_ret_valid,
    output logic                          o_ret_ready,
    input  logic [CMD_ID_W-1:0]           i_ret_cmd_id,
    input  logic                          i_qry_valid,
    output logic                          o_qry_ready,
    input  logic [CMD_ID_W-1:0]           i_qry_cmd_id,
    output logic                          o_ret_done,
    output logic                          o_ret_hit,
    output logic                          o_qry_rsp_valid,
    output logic                          o_qry_exists,
    output logic [$clog2(PROC_COUNT)-1:0] o_qry_proc_id,
    output entry_t                        o_sb_entry,
    output logic                          o_sb_write,
    output logic                          o_sb_read,
    output logic                          o_sb_flush,
    input  logic                          i_sb_ack,
    input  logic                          i_sb_exists,
    input  logic [$clog2(PROC_COUNT)-1:0] i_sb_id,
    output logic [$clog2(PROC_COUNT):0]   o_count,
    output logic                          o_full,
    output logic                          o_timeout
);
    localparam int PID_W = $clog2(PROC_COUNT);
    localparam int CNT_W = PID_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PROC_COUNT - 1);

    state_t             r_state, w_state_nxt;
    op_t                r_op, w_in_op;
    entry_t             r_entry, w_in_entry;
    logic               r_exists, r_acked;
    logic [PID_W-1:0]   r_id;
    logic [CNT_W-1:0]   r_count;
    logic [2:0]         w_grant;
    logic [CMD_ID_W-1:0] w_in_cmd;
    logic               w_accept;
    logic               w_tmo_hit;

    rr_arb3 u_arb (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_req    ({i_qry_valid, i_iss_valid, i_ret_valid} & {3{r_state == ST_IDLE}}),
        .i_mask   ({1'b0, o_full, 1'b0}),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    assign w_accept    = |w_grant;
    assign o_ret_ready = w_grant[PORT_RET];
    assign o_iss_ready = w_grant[PORT_ISS];
    assign o_qry_ready = w_grant[PORT_QRY];

    always_comb begin
        w_in_op    = OP_READ;
        w_in_cmd   = i_qry_cmd_id;
        w_in_entry = '0;
        if (w_grant[PORT_RET]) begin
            w_in_op  = OP_FLUSH;
            w_in_cmd = i_ret_cmd_id;
        end else if (w_grant[PORT_ISS]) begin
            w_in_op  = OP_WRITE;
            w_in_cmd = i_iss_entry.cmd_id;
        end
        // Only writes carry a proc_id; lookups and removals send proc_id 0.
        if (w_grant[PORT_ISS]) w_in_entry = i_iss_entry;
        else                   w_in_entry.cmd_id = w_in_cmd;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // cmd_id 0 is the empty marker: never reaches the scoreboard.
                    if (w_in_cmd == '0) w_state_nxt = w_grant[PORT_ISS] ? ST_IDLE : ST_RESP;
                    else                w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (i_sb_ack || w_tmo_hit) w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_WRITE;
            r_entry  <= '0;
            r_exists <= 1'b0;
            r_acked  <= 1'b0;
            r_id     <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_accept) begin
                r_op     <= w_in_op;
                r_entry  <= w_in_entry;
                r_exists <= 1'b0;
                r_acked  <= 1'b0;
                r_id     <= '0;
            end
            if (r_state == ST_WAIT && i_sb_ack) begin
                r_exists <= i_sb_exists;
                r_acked  <= 1'b1;
                r_id     <= i_sb_exists ? i_sb_id : '0;
            end
            // Count only on an acknowledged write, so a watchdog abort leaves it alone.
            if (r_state == ST_RESP) begin
                if (r_op == OP_WRITE && r_acked && r_count != CNT_MAX)
                    r_count <= r_count + CNT_W'(1);
                else if (r_op == OP_FLUSH && r_exists && r_count != '0)
                    r_count <= r_count - CNT_W'(1);
            end
        end
    end

`ifdef SB_CTRL_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TMO_W-1:0] r_wait_cnt;
    logic             r_timeout;

    // Loaded while the strobe is out; hitting zero in WAIT without ack is the TIMEOUT-th cycle.
    assign w_tmo_hit = (r_state == ST_WAIT) && !i_sb_ack && (r_wait_cnt == '0);
    assign o_timeout = r_timeout;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE)
                r_wait_cnt <= TMO_W'(TIMEOUT - 1);
            else if (r_state == ST_WAIT && r_wait_cnt != '0)
                r_wait_cnt <= r_wait_cnt - TMO_W'(1);
            if (w_tmo_hit) r_timeout <= 1'b1;
        end
    end
`else
    logic w_tmo_unused;
    assign w_tmo_unused = (TIMEOUT > 0);
    assign w_tmo_hit    = 1'b0;
    assign o_timeout    = 1'b0;
`endif

    assign o_sb_entry      = r_entry;
    assign o_sb_write      = (r_state == ST_ISSUE) && (r_op == OP_WRITE);
    assign o_sb_read       = (r_state == ST_ISSUE) && (r_op == OP_READ);
    assign o_sb_flush      = (r_state == ST_ISSUE) && (r_op == OP_FLUSH);
    assign o_ret_done      = (r_state == ST_RESP) && (r_op == OP_FLUSH);
    assign o_ret_hit       = o_ret_done && r_exists;
    assign o_qry_rsp_valid = (r_state == ST_RESP) && (r_op == OP_READ);
    assign o_qry_exists    = o_qry_rsp_valid && r_exists;
    assign o_qry_proc_id   = o_qry_rsp_valid ? r_id : '0;
    assign o_count         = r_count;
    assign o_full          = (r_count == CNT_MAX);
endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl (PROC_COUNT = 8) with a small
// behavioural scoreboard that acks a configurable number of cycles after
// each strobe. The watchdog section follows SB_CTRL_TIMEOUT_EN.
module tb_scoreboard_ctrl;
    import sb_pkg::*;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_iss_valid = 1'b0, i_ret_valid = 1'b0, i_qry_valid = 1'b0;
    entry_t        i_iss_entry = '0;
    logic [7:0]    i_ret_cmd_id = '0, i_qry_cmd_id = '0;
    logic          i_sb_ack = 1'b0, i_sb_exists = 1'b0;
    logic [2:0]    i_sb_id = '0;
    logic          o_iss_ready, o_ret_ready, o_qry_ready;
    logic          o_ret_done, o_ret_hit, o_qry_rsp_valid, o_qry_exists;
    logic [2:0]    o_qry_proc_id;
    entry_t        o_sb_entry;
    logic          o_sb_write, o_sb_read, o_sb_flush;
    logic [3:0]    o_count;
    logic          o_full, o_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    scoreboard_ctrl dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_iss_valid(i_iss_valid), .o_iss_ready(o_iss_ready), .i_iss_entry(i_iss_entry),
        .i_ret_valid(i_ret_valid), .o_ret_ready(o_ret_ready), .i_ret_cmd_id(i_ret_cmd_id),
        .i_qry_valid(i_qry_valid), .o_qry_ready(o_qry_ready), .i_qry_cmd_id(i_qry_cmd_id),
        .o_ret_done(o_ret_done), .o_ret_hit(o_ret_hit),
        .o_qry_rsp_valid(o_qry_rsp_valid), .o_qry_exists(o_qry_exists), .o_qry_proc_id(o_qry_proc_id),
        .o_sb_entry(o_sb_entry), .o_sb_write(o_sb_write), .o_sb_read(o_sb_read), .o_sb_flush(o_sb_flush),
        .i_sb_ack(i_sb_ack), .i_sb_exists(i_sb_exists), .i_sb_id(i_sb_id),
        .o_count(o_count), .o_full(o_full), .o_timeout(o_timeout)
    );

    // Behavioural scoreboard.
    logic       m_exists [256];
    logic [2:0] m_pid    [256];
    int         ack_dly = 2;
    bit         ack_en  = 1'b1;
    bit         pend    = 1'b0;
    int         pcnt    = 0;
    op_t        pop     = OP_WRITE;
    entry_t     pent    = '0;

    always @(negedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            i_sb_ack = 1'b0; i_sb_exists = 1'b0; i_sb_id = '0; pend = 1'b0;
            for (int i = 0; i < 256; i++) begin m_exists[i] = 1'b0; m_pid[i] = '0; end
        end else if (!i_clk) begin
            i_sb_ack = 1'b0; i_sb_exists = 1'b0; i_sb_id = '0;
            if (pend && ack_en) begin
                pcnt--;
                if (pcnt <= 0) begin
                    pend = 1'b0;
                    i_sb_ack = 1'b1;
                    case (pop)
                        OP_WRITE: begin
                            m_exists[pent.cmd_id] = 1'b1; m_pid[pent.cmd_id] = pent.proc_id;
                            i_sb_exists = 1'b1; i_sb_id = pent.proc_id;
                        end
                        OP_READ: begin
                            i_sb_exists = m_exists[pent.cmd_id]; i_sb_id = m_pid[pent.cmd_id];
                        end
                        default: begin
                            i_sb_exists = m_exists[pent.cmd_id]; i_sb_id = m_pid[pent.cmd_id];
                            m_exists[pent.cmd_id] = 1'b0;
                        end
                    endcase
                end
            end else if (!ack_en) begin
                pend = 1'b0;
            end
            if (o_sb_write || o_sb_read || o_sb_flush) begin
                pend = 1'b1; pcnt = ack_dly; pent = o_sb_entry;
                pop  = o_sb_write ? OP_WRITE : (o_sb_read ? OP_READ : OP_FLUSH);
            end
        end
    end

    // Event monitor, sampled mid-cycle.
    int     cyc = 0;
    int     n_wr = 0, n_rd = 0, n_fl = 0, n_ret_done = 0, n_qry_rsp = 0, n_overlap = 0;
    logic   last_hit = 1'b0, last_qex = 1'b0;
    logic [2:0] last_qpid = '0;
    entry_t last_wr = '0, last_rd = '0;
    int     t_ret_done = 0, t_qry_rsp = 0, t_ret_acc = 0, t_iss_acc = 0, t_qry_acc = 0;
    int     order[$];
    bit     iss_ready_seen = 1'b0;

    always @(negedge i_clk) begin
        #2;
        cyc++;
        if (o_sb_write) begin n_wr++; last_wr = o_sb_entry; end
        if (o_sb_read)  begin n_rd++; last_rd = o_sb_entry; end
        if (o_sb_flush) n_fl++;
        if ($countones({o_sb_write, o_sb_read, o_sb_flush}) > 1) n_overlap++;
        if ($countones({o_iss_ready, o_ret_ready, o_qry_ready}) > 1) n_overlap++;
        if (o_ret_done) begin n_ret_done++; last_hit = o_ret_hit; t_ret_done = cyc; end
        if (o_qry_rsp_valid) begin n_qry_rsp++; last_qex = o_qry_exists; last_qpid = o_qry_proc_id; t_qry_rsp = cyc; end
        if (i_ret_valid && o_ret_ready) begin order.push_back(0); t_ret_acc = cyc; end
        if (i_iss_valid && o_iss_ready) begin order.push_back(1); t_iss_acc = cyc; end
        if (i_qry_valid && o_qry_ready) begin order.push_back(2); t_qry_acc = cyc; end
        if (o_iss_ready) iss_ready_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Present a request, hold it until the handshake, then drop valid.
    task automatic req(input int port, input logic [7:0] cmd, input logic [2:0] pid);
        int  k;
        bit  rdy;
        @(negedge i_clk);
        case (port)
            0:       begin i_ret_valid = 1'b1; i_ret_cmd_id = cmd; end
            1:       begin i_iss_valid = 1'b1; i_iss_entry.cmd_id = cmd; i_iss_entry.proc_id = pid; end
            default: begin i_qry_valid = 1'b1; i_qry_cmd_id = cmd; end
        endcase
        for (k = 0; k < 40; k++) begin
            #1;
            rdy = (port == 0) ? o_ret_ready : ((port == 1) ? o_iss_ready : o_qry_ready);
            if (rdy) break;
            @(negedge i_clk);
        end
        check($sformatf("handshake_p%0d_cmd%0d", port, cmd), {31'd0, k < 40}, 32'd1);
        @(posedge i_clk);
        #1;
        case (port)
            0:       i_ret_valid = 1'b0;
            1:       i_iss_valid = 1'b0;
            default: i_qry_valid = 1'b0;
        endcase
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rstn = 1'b0;
        cycles(2);
        i_rstn = 1'b1;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({o_count, o_full, o_sb_write, o_sb_read, o_sb_flush, o_ret_done, o_ret_hit,
                    o_qry_rsp_valid, o_qry_exists, o_qry_proc_id, o_timeout,
                    o_iss_ready, o_ret_ready, o_qry_ready}) | 32'(o_sb_entry);
    endfunction

    initial begin
        int s0, q0, k;

        // Reset state.
        cycles(3);
        i_rstn = 1'b1;
        #1;
        check("reset_outputs", all_outs(), 32'd0);
        check("reset_count", 32'(o_count), 32'd0);

        // Insert {5,3}; ack two cycles after the strobe.
        req(1, 8'd5, 3'd3);
        cycles(8);
        check("ins_write_pulses", n_wr, 1);
        check("ins_write_entry", 32'(last_wr), 32'({8'd5, 3'd3}));
        check("ins_count", 32'(o_count), 32'd1);
        check("ins_no_rsp", n_ret_done + n_qry_rsp, 0);

        // Lookups with ack on the first WAIT cycle.
        ack_dly = 1;
        req(2, 8'd5, 3'd0);
        cycles(6);
        check("qry5_rsp", n_qry_rsp, 1);
        check("qry5_exists", 32'(last_qex), 32'd1);
        check("qry5_pid", 32'(last_qpid), 32'd3);
        check("qry5_rd_entry", 32'(last_rd), 32'({8'd5, 3'd0}));
        check("qry5_latency", t_qry_rsp - t_qry_acc, 3);
        req(2, 8'd9, 3'd0);
        cycles(6);
        check("qry9_exists", 32'(last_qex), 32'd0);
        check("qry9_pid", 32'(last_qpid), 32'd0);

        // Three simultaneous requesters from reset.
        do_reset();
        order.delete();
        s0 = n_overlap;
        fork
            req(0, 8'd7, 3'd0);
            req(1, 8'd12, 3'd4);
            req(2, 8'd12, 3'd0);
        join
        cycles(6);
        check("rr_accepts", order.size(), 3);
        if (order.size() == 3) begin
            check("rr_first", order[0], 0);
            check("rr_second", order[1], 1);
            check("rr_third", order[2], 2);
        end
        check("rr_no_overlap", n_overlap - s0, 0);
        check("rr_ret_hit", 32'(last_hit), 32'd0);
        check("rr_qry_exists", 32'(last_qex), 32'd1);
        check("rr_qry_pid", 32'(last_qpid), 32'd4);
        check("rr_count", 32'(o_count), 32'd1);

        // Fill to PROC_COUNT-1.
        for (int i = 0; i < 6; i++) req(1, 8'(20 + i), 3'(i + 1));
        cycles(6);
        check("fill_count", 32'(o_count), 32'd7);
        check("fill_full", 32'(o_full), 32'd1);

        // Issue held while full; query still served.
        @(negedge i_clk);
        i_iss_valid = 1'b1; i_iss_entry.cmd_id = 8'd30; i_iss_entry.proc_id = 3'd1;
        iss_ready_seen = 1'b0;
        req(2, 8'd20, 3'd0);
        cycles(6);
        check("full_iss_blocked", 32'(iss_ready_seen), 32'd0);
        check("full_qry_exists", 32'(last_qex), 32'd1);
        check("full_qry_pid", 32'(last_qpid), 32'd1);

        // Retire a hit; the pending issue is taken in the very next IDLE.
        t_iss_acc = -1;
        req(0, 8'd20, 3'd0);
        for (k = 0; k < 20; k++) begin
            @(negedge i_clk);
            #3;
            if (t_iss_acc >= 0) break;
        end
        check("full_iss_accepted", {31'd0, k < 20}, 32'd1);
        check("ret_hit", 32'(last_hit), 32'd1);
        check("ret_count", 32'(o_count), 32'd6);
        check("ret_not_full", 32'(o_full), 32'd0);
        check("iss_after_ret", t_iss_acc - t_ret_done, 1);
        @(posedge i_clk);
        #1 i_iss_valid = 1'b0;
        cycles(6);
        check("refill_count", 32'(o_count), 32'd7);

        // Retire cmd 0: straight to a miss response, no strobe.
        s0 = n_wr + n_rd + n_fl;
        q0 = n_ret_done;
        req(0, 8'd0, 3'd0);
        cycles(4);
        check("ret0_done", n_ret_done, q0 + 1);
        check("ret0_hit", 32'(last_hit), 32'd0);
        check("ret0_no_strobe", n_wr + n_rd + n_fl, s0);
        check("ret0_latency", t_ret_done - t_ret_acc, 1);

        // Reset while waiting for ack.
        ack_en = 1'b0;
        q0 = n_qry_rsp;
        req(2, 8'd30, 3'd0);
        cycles(2);
        i_rstn = 1'b0;
        #1;
        check("wait_rst_outputs", all_outs(), 32'd0);
        check("wait_rst_count", 32'(o_count), 32'd0);
        cycles(2);
        i_rstn = 1'b1;
        ack_en = 1'b1;
        cycles(6);
        check("wait_rst_no_rsp", n_qry_rsp, q0);

        // Issue cmd 0 is dropped.
        s0 = n_wr;
        req(1, 8'd0, 3'd5);
        cycles(6);
        check("iss0_count", 32'(o_count), 32'd0);
        check("iss0_no_write", n_wr, s0);
        req(1, 8'd3, 3'd2);
        cycles(6);
        check("iss3_count", 32'(o_count), 32'd1);

`ifdef SB_CTRL_TIMEOUT_EN
        ack_en = 1'b0;
        q0 = n_qry_rsp;
        req(2, 8'd3, 3'd0);
        cycles(40);
        check("tmo_not_yet", 32'(o_timeout), 32'd0);
        cycles(35);
        check("tmo_set", 32'(o_timeout), 32'd1);
        check("tmo_rsp", n_qry_rsp, q0 + 1);
        check("tmo_exists", 32'(last_qex), 32'd0);
        check("tmo_count", 32'(o_count), 32'd1);
        ack_en = 1'b1;
        req(2, 8'd3, 3'd0);
        cycles(6);
        check("tmo_after_exists", 32'(last_qex), 32'd1);
        check("tmo_after_pid", 32'(last_qpid), 32'd2);
        check("tmo_sticky", 32'(o_timeout), 32'd1);
`else
        ack_en = 1'b0;
        q0 = n_qry_rsp;
        req(2, 8'd3, 3'd0);
        cycles(100);
        check("nowd_no_rsp", n_qry_rsp, q0);
        check("nowd_timeout", 32'(o_timeout), 32'd0);
        do_reset();
        ack_en = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/scoreboard_ctrl.md
# scoreboard_ctrl

Sequencing front-end for the scoreboard, the cmd_id→proc_id hashmap. It takes issue (insert), retire (remove) and query (lookup) requests from three independent requesters, grants one at a time round-robin, and drives the scoreboard's strobe/ack interface. It holds the scoreboard entry stable for the whole operation, tracks occupancy so an insert never stalls for lack of a free slot, and returns results on per-port response pulses. It sits between the issuer/retire logic and the scoreboard instance.

## Interface
- PROC_COUNT, `PROC_COUNT: scoreboard slots; power of 2.
- TIMEOUT, 64: ack watchdog limit in cycles; used only with SB_CTRL_TIMEOUT_EN.
- Clock and reset: one clock; reset is asynchronous and active-low. Ports `i_clk` and `i_rstn`.
- i_clk  in  1  clock
- i_rstn  in  1  async active-low reset
- i_iss_valid / o_iss_ready  in/out  1  issue handshake
- i_iss_entry  in  entry_t  entry to insert
- i_ret_valid / o_ret_ready  in/out  1  retire handshake
- i_ret_cmd_id  in  CMD_ID_W  cmd to remove
- i_qry_valid / o_qry_ready  in/out  1  query handshake
- i_qry_cmd_id  in  CMD_ID_W  cmd to look up
- o_ret_done  out  1  retire complete pulse; o_ret_hit  out  1  entry existed
- o_qry_rsp_valid  out  1  query result pulse; o_qry_exists  out  1; o_qry_proc_id  out  $clog2(PROC_COUNT)
- o_sb_entry  out  entry_t  to scoreboard i_entry
- o_sb_write / o_sb_read / o_sb_flush  out  1  scoreboard strobes
- i_sb_ack / i_sb_exists  in  1; i_sb_id  in  $clog2(PROC_COUNT)  scoreboard outputs
- o_count  out  $clog2(PROC_COUNT)+1  live entries
- o_full  out  1  o_count == PROC_COUNT-1
- o_timeout  out  1  sticky watchdog flag

## Operation
- FSM: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: readies are high only in IDLE, only for the single port granted this cycle (ready = grant). Issue is masked from arbitration while o_full. A handshake latches op and entry, then moves to ISSUE.
- Arbitration: 3-way round-robin over {retire, issue, query}. The pointer moves to one past the last winner. After reset it starts at retire.
- ISSUE: the matching strobe is high for exactly one cycle. o_sb_entry = latched entry: the full entry for write, or {cmd_id, proc_id=0} for read/flush.
- WAIT: all strobes are low. o_sb_entry is held. Leave on i_sb_ack, capturing i_sb_exists and i_sb_id.
- RESP: one-cycle response pulse for the owning port; then IDLE.
  - Issue: no response pulse; o_count +1.
  - Retire: o_ret_done=1 and o_ret_hit=captured exists; if hit, o_count −1.
  - Query: o_qry_rsp_valid=1, o_qry_exists and o_qry_proc_id as captured. o_qry_proc_id is forced to 0 when exists=0.
- cmd_id 0 is the empty marker and is never sent to the scoreboard.
  - Issue with cmd_id 0: accepted, dropped, goes directly to IDLE.
  - Retire/query with cmd_id 0: go directly to RESP with hit/exists=0.
- o_count saturates at 0 on decrement and never exceeds PROC_COUNT-1.

## Timing
- Reset value of every output is 0. State=IDLE, o_count=0, RR pointer=retire, o_timeout=0.
- Reset mid-operation aborts the operation with no response pulse. The scoreboard shares i_rstn.
- Minimum latency with ack on the first WAIT cycle:
  - handshake at cycle T, strobe at T+1, ack at T+2, response pulse at T+3, ready again at T+4.
- Throughput: one operation per 4 cycles minimum.
- Response and count update happen together in RESP, so o_full is already updated in the next IDLE.
- Simultaneous valids: exactly one ready is asserted. The others wait; valid must be held until ready, and payload must stay stable while valid.
- i_sb_ack during ISSUE is ignored. Only WAIT samples ack.

## Configuration
- SB_CTRL_TIMEOUT_EN defined:
  - A WAIT-cycle counter runs. After TIMEOUT cycles without ack, o_timeout sets and stays set until reset.
  - The FSM goes to RESP with exists/hit=0 and no count change.
- Not defined: WAIT waits indefinitely, and o_timeout is tied to 0.

## Structure
- Package sb_pkg holds:
  - entry_t {cmd_id, proc_id} and CMD_ID_W;
  - op enum {OP_WRITE, OP_READ, OP_FLUSH};
  - controller state enum.
- The scoreboard uses the same entry_t.
- Sub-module rr_arb3: 3-input round-robin arbiter with a request mask. It outputs a one-hot grant and advances its pointer on an accept strobe.

## Test plan
- Issue {cmd 5, proc 3}, scoreboard model acks 2 cycles after the strobe → one o_sb_write pulse, o_count 0→1, no response pulse.
- Query cmd 5 after the insert → o_qry_rsp_valid, exists=1, proc_id=3. Query cmd 9 → exists=0, proc_id=0.
- Retire, issue and query valid in the same cycle from reset → grants in order retire, issue, query, one readiness window each, no overlapping strobes.
- Fill to PROC_COUNT-1 → o_full=1 and o_iss_ready stays 0 while query/retire still proceed. Retire a hit → o_count −1, issue accepted next IDLE.
- Retire cmd 0 → o_ret_done with hit=0, no scoreboard strobe. Deassert i_rstn during WAIT → all outputs 0, no response pulse.
- With SB_CTRL_TIMEOUT_EN and no ack → o_timeout set after 64 WAIT cycles, query response exists=0, state back to IDLE.
